parity_frame_checker: RTL
=========================

# parity_frame_checker

Sequencing controller for the even-parity checking datapath. Accepts a frame of FRAME_LEN 4-bit words, each with its even-parity bit, over a valid/ready handshake. Checks each word, reports a per-word error flag, and accumulates a frame error count. It sits between a nibble source (serial deserializer or test pattern generator) and the status/reporting logic, and gives start/done sequencing to what is otherwise a purely combinational check.

## Interface
Parameters:
- FRAME_LEN, 16: words per frame. Must be ≥1 and ≤2^CNT_W−1.
- CNT_W, 5: width of the word index and error counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a frame. Sampled only in IDLE.
- in_valid  in  1  source has a word.
- in_data  in  4  data nibble.
- in_parity  in  1  even-parity bit supplied with the word.
- in_ready  out  1  block accepts a word this cycle.
- busy  out  1  high in RUN and DONE.
- word_err  out  1  registered error flag of the last accepted word.
- word_err_valid  out  1  one-cycle pulse qualifying word_err.
- done  out  1  one-cycle end-of-frame pulse.
- err_count  out  CNT_W  errored words in the current or last frame.
- frame_ok  out  1  last completed frame had zero errors.

## Operation
- Reset: state IDLE. in_ready, busy, word_err, word_err_valid, done and frame_ok are 0. err_count and the word index are 0.
- Word error: err = ^{in_data, in_parity}. 1 means odd total, which is a parity violation.
- The FSM has three states, encoded 2 bits.
  - IDLE: in_ready=0. If start=1, go to RUN, clear err_count and the index to 0, and clear frame_ok to 0.
  - RUN: in_ready=1. A word is accepted when in_valid & in_ready.
    - On accept: register word_err=err, pulse word_err_valid, and increment the index.
    - If err=1, increment err_count, saturating at 2^CNT_W−1.
    - If the accepted index equals FRAME_LEN−1, go to DONE.
    - Without an accept, the FSM holds and no outputs change.
  - DONE: done=1 and in_ready=0. frame_ok=(final err_count==0). Unconditionally go to IDLE next cycle.
- err_count and frame_ok hold their values in IDLE until the next start.
- start asserted in RUN or DONE is ignored. There is no abort.
- in_data and in_parity are don't-care when the word is not accepted.
- With FRAME_LEN=1, a single accepted word moves the FSM straight from RUN to DONE.

## Timing
- Start: start high in IDLE at cycle T → RUN at T+1, with in_ready=1 at T+1.
- Per-word latency is 1: a word accepted at cycle N → word_err and word_err_valid at N+1. err_count reflects the word at N+1.
- Last word accepted at N:
  - DONE at N+1, with done=1, final err_count and frame_ok valid.
  - IDLE at N+2.
  - The earliest next start is at N+2, giving RUN at N+3.
- Back-to-back accepts give one word per cycle. There are no bubbles inside RUN.
- Reset mid-frame: all state returns to reset values immediately (asynchronous), and any partial frame is discarded.
- word_err holds its value between pulses. Consumers use only word_err_valid.

## Configuration
- PFC_FIRST_ERR_EN defined adds two outputs:
  - first_err_seen (out, 1): set on the first errored word of a frame.
  - first_err_idx (out, CNT_W): index of that word.
  - Both clear on start and on reset, and hold until the next start.
  - Both update at the same cycle as word_err_valid.
- PFC_FIRST_ERR_EN undefined: these ports and their registers are absent. All other behaviour is identical.

## Structure
- Shared package pfc_pkg holds:
  - State encodings: PFC_IDLE=2'd0, PFC_RUN=2'd1, PFC_DONE=2'd2.
  - The nibble width constant PFC_DW=4.
- Sub-module parity_calc4: purely combinational, inputs {in_data, in_parity}, output err. Instantiated once. The FSM, counters and output registers live in parity_frame_checker.

## Test plan
- Reset check: hold rst for 2 cycles → every output is 0 and the state is IDLE, including when rst is asserted mid-RUN after 5 words.
- Clean frame: FRAME_LEN=16, start, send 16 words in=i with correct parity (for example 4'b0011,p=0 and 4'b0001,p=1) back-to-back → 16 word_err_valid pulses with word_err=0. done comes 1 cycle after the last accept with err_count=0 and frame_ok=1.
- Errored frame: flip parity on words 3, 7 and 15 → word_err=1 at exactly those pulses. At done, err_count=3, frame_ok=0, and (with PFC_FIRST_ERR_EN) first_err_idx=3.
- Stalls: toggle in_valid with a 50% random pattern → exactly 16 accepts, done only after the 16th, and no output changes during stalls.
- Ignored start and saturation:
  - Pulse start during RUN and in DONE → no restart. A start at the first IDLE cycle after done is accepted.
  - CNT_W=2, FRAME_LEN=3 with all words errored → err_count reaches 3 and does not wrap.

Source files
------------

// File: rtl/pfc_pkg.sv
// Shared constants for the parity frame checker: FSM state encodings and nibble width.
package pfc_pkg;

    localparam int unsigned PFC_DW = 4;
    localparam int unsigned PFC_SW = 2;

    localparam logic [PFC_SW-1:0] PFC_IDLE = 2'd0;
    localparam logic [PFC_SW-1:0] PFC_RUN  = 2'd1;
    localparam logic [PFC_SW-1:0] PFC_DONE = 2'd2;

endpackage

// File: rtl/parity_frame_checker_calc.sv
// parity_calc4: combinational even-parity check of one nibble plus its parity bit.
module parity_calc4
    import pfc_pkg::*;
(
    input  logic [PFC_DW-1:0] in_data,
    input  logic              in_parity,
    output logic              err
);

    // Odd total across data and parity means the even-parity rule was violated.
    assign err = ^{in_data, in_parity};

endmodule

// File: rtl/parity_frame_checker.sv
// Frame sequencer around parity_calc4: valid/ready word intake, per-word error flag, frame error count.
// Optional first-error capture is built when PFC_FIRST_ERR_EN is defined.
module parity_frame_checker
    import pfc_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [PFC_DW-1:0] in_data,
    input  logic              in_parity,
    output logic              in_ready,
    output logic              busy,
    output logic              word_err,
    output logic              word_err_valid,
    output logic              done,
    output logic [CNT_W-1:0]  err_count,
`ifdef PFC_FIRST_ERR_EN
    output logic              first_err_seen,
    output logic [CNT_W-1:0]  first_err_idx,
`endif
    output logic              frame_ok
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    logic [PFC_SW-1:0] state_q, state_n;
    logic [CNT_W-1:0]  idx_q, idx_n;
    logic [CNT_W-1:0]  err_count_n;
    logic              in_ready_n, busy_n, word_err_n, word_err_valid_n, done_n, frame_ok_n;
    logic              err;
`ifdef PFC_FIRST_ERR_EN
    logic              first_err_seen_n;
    logic [CNT_W-1:0]  first_err_idx_n;
`endif

    parity_calc4 u_calc (
        .in_data   (in_data),
        .in_parity (in_parity),
        .err       (err)
    );

    // Next-state and next-output logic; everything holds unless a transition or accept changes it.
    always_comb begin
        state_n          = state_q;
        idx_n            = idx_q;
        err_count_n      = err_count;
        word_err_n       = word_err;
        word_err_valid_n = 1'b0;
        done_n           = 1'b0;
        frame_ok_n       = frame_ok;
`ifdef PFC_FIRST_ERR_EN
        first_err_seen_n = first_err_seen;
        first_err_idx_n  = first_err_idx;
`endif
        case (state_q)
            PFC_IDLE: begin
                if (start) begin
                    state_n     = PFC_RUN;
                    idx_n       = '0;
                    err_count_n = '0;
                    frame_ok_n  = 1'b0;
`ifdef PFC_FIRST_ERR_EN
                    first_err_seen_n = 1'b0;
                    first_err_idx_n  = '0;
`endif
                end
            end
            PFC_RUN: begin
                if (in_valid && in_ready) begin
                    word_err_n       = err;
                    word_err_valid_n = 1'b1;
                    idx_n            = idx_q + CNT_W'(1);
                    if (err && (err_count != CNT_MAX)) begin
                        err_count_n = err_count + CNT_W'(1);
                    end
`ifdef PFC_FIRST_ERR_EN
                    if (err && !first_err_seen) begin
                        first_err_seen_n = 1'b1;
                        first_err_idx_n  = idx_q;
                    end
`endif
                    // Final word: frame verdict is registered alongside the DONE entry.
                    if (idx_q == LAST_IDX) begin
                        state_n    = PFC_DONE;
                        done_n     = 1'b1;
                        frame_ok_n = (err_count_n == '0);
                    end
                end
            end
            PFC_DONE: begin
                state_n = PFC_IDLE;
            end
            default: begin
                state_n = PFC_IDLE;
            end
        endcase
        in_ready_n = (state_n == PFC_RUN);
        busy_n     = (state_n != PFC_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= PFC_IDLE;
            idx_q          <= '0;
            err_count      <= '0;
            in_ready       <= 1'b0;
            busy           <= 1'b0;
            word_err       <= 1'b0;
            word_err_valid <= 1'b0;
            done           <= 1'b0;
            frame_ok       <= 1'b0;
`ifdef PFC_FIRST_ERR_EN
            first_err_seen <= 1'b0;
            first_err_idx  <= '0;
`endif
        end else begin
            state_q        <= state_n;
            idx_q          <= idx_n;
            err_count      <= err_count_n;
            in_ready       <= in_ready_n;
            busy           <= busy_n;
            word_err       <= word_err_n;
            word_err_valid <= word_err_valid_n;
            done           <= done_n;
            frame_ok       <= frame_ok_n;
`ifdef PFC_FIRST_ERR_EN
            first_err_seen <= first_err_seen_n;
            first_err_idx  <= first_err_idx_n;
`endif
        end
    end

endmodule
